// File: rtl/sevenseg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sevenseg_pkg                                                  |
// | Brief    : Glyph constants and digit-slot enum for the 7-seg scan driver |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package sevenseg_pkg;

   typedef enum logic [1:0] {
      DIG_UNITS = 2'd0,
      DIG_TENS  = 2'd1,
      DIG_BLANK = 2'd2,
      DIG_MODE  = 2'd3
   } digit_idx_e;

   // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] c_SEG_0     = 7'b1000000;
   localparam logic [6:0] c_SEG_1     = 7'b1111001;
   localparam logic [6:0] c_SEG_2     = 7'b0100100;
   localparam logic [6:0] c_SEG_3     = 7'b0110000;
   localparam logic [6:0] c_SEG_4     = 7'b0011001;
   localparam logic [6:0] c_SEG_5     = 7'b0010010;
   localparam logic [6:0] c_SEG_6     = 7'b0000010;
   localparam logic [6:0] c_SEG_7     = 7'b1111000;
   localparam logic [6:0] c_SEG_8     = 7'b0000000;
   localparam logic [6:0] c_SEG_9     = 7'b0010000;
   localparam logic [6:0] c_SEG_U     = 7'b1000001;
   localparam logic [6:0] c_SEG_D     = 7'b0100001;
   localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

   // Decoder codes above 9 select the direction letters
   localparam logic [3:0] c_CODE_U = 4'd10;
   localparam logic [3:0] c_CODE_D = 4'd11;

   function automatic logic [3:0] anode_sel(input digit_idx_e idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_7seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bin_to_7seg                                                   |
// | Brief    : Combinational glyph decoder (0-9, U, d, blank), active-low    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bin_to_7seg
   import sevenseg_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = c_SEG_BLANK;
      if (!blank) begin
         case (value)
            4'd0:     seg = c_SEG_0;
            4'd1:     seg = c_SEG_1;
            4'd2:     seg = c_SEG_2;
            4'd3:     seg = c_SEG_3;
            4'd4:     seg = c_SEG_4;
            4'd5:     seg = c_SEG_5;
            4'd6:     seg = c_SEG_6;
            4'd7:     seg = c_SEG_7;
            4'd8:     seg = c_SEG_8;
            4'd9:     seg = c_SEG_9;
            c_CODE_U: seg = c_SEG_U;
            c_CODE_D: seg = c_SEG_D;
            default:  seg = c_SEG_BLANK;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sevenseg_scan_driver                                          |
// | Brief    : 4-digit multiplexed display of a 0..15 counter plus U/d mode. |
// |            Define SEVENSEG_GHOST_BLANK_EN to blank anodes for the first  |
// |            BLANK_CYCLES clocks of every digit slot.                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sevenseg_scan_driver
   import sevenseg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count,
   input  logic       direction,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);
   localparam logic [RCNT_W-1:0] c_RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

   if ((REFRESH_DIV < 4) || (BLANK_CYCLES < 1) || (BLANK_CYCLES >= REFRESH_DIV)) begin : g_bad_params
      $error("sevenseg_scan_driver: need REFRESH_DIV >= 4 and 1 <= BLANK_CYCLES < REFRESH_DIV");
   end

   logic [RCNT_W-1:0] r_rcnt;
   digit_idx_e        r_idx;
   logic [3:0]        r_snap_cnt;
   logic              r_snap_dir;
   logic              r_load_pend;
   logic [6:0]        r_seg;
   logic [3:0]        r_an;

   logic [RCNT_W-1:0] w_rcnt_next;
   digit_idx_e        w_idx_next;
   logic              w_slot_end;
   logic              w_snap_load;
   logic              w_ge10;
   logic [3:0]        w_units;
   logic [3:0]        w_val;
   logic              w_blank;
   logic [6:0]        w_seg;
   logic              w_ghost;
   logic [3:0]        w_an_next;

   // Snapshot reloads only at the last clock of the mode slot, or right after reset
   always_comb begin
      w_slot_end  = (r_rcnt == c_RCNT_LAST);
      w_rcnt_next = w_slot_end ? '0 : r_rcnt + 1'b1;
      w_idx_next  = w_slot_end ? digit_idx_e'(r_idx + 2'd1) : r_idx;
      w_snap_load = r_load_pend | (w_slot_end & (r_idx == DIG_MODE));
   end

   // One compare-and-subtract suffices for a 4-bit value
   always_comb begin
      w_ge10  = (r_snap_cnt >= 4'd10);
      w_units = w_ge10 ? (r_snap_cnt - 4'd10) : r_snap_cnt;
   end

   always_comb begin
      w_val   = 4'd0;
      w_blank = 1'b1;
      case (r_idx)
         DIG_UNITS: begin
            w_val   = w_units;
            w_blank = 1'b0;
         end
         DIG_TENS: begin
            w_val   = 4'd1;
            w_blank = ~w_ge10;
         end
         DIG_MODE: begin
            w_val   = r_snap_dir ? c_CODE_U : c_CODE_D;
            w_blank = 1'b0;
         end
         default: begin
            w_val   = 4'd0;
            w_blank = 1'b1;
         end
      endcase
   end

   bin_to_7seg u_decode (
      .value (w_val),
      .blank (w_blank),
      .seg   (w_seg)
   );

`ifdef SEVENSEG_GHOST_BLANK_EN
   assign w_ghost = (r_rcnt < RCNT_W'(BLANK_CYCLES));
`else
   assign w_ghost = 1'b0;
`endif

   assign w_an_next = w_ghost ? 4'b1111 : anode_sel(r_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rcnt      <= '0;
         r_idx       <= DIG_UNITS;
         r_snap_cnt  <= 4'd0;
         r_snap_dir  <= 1'b0;
         r_load_pend <= 1'b1;
         r_an        <= 4'b1111;
         r_seg       <= c_SEG_BLANK;
      end else begin
         r_rcnt      <= w_rcnt_next;
         r_idx       <= w_idx_next;
         r_load_pend <= 1'b0;
         if (w_snap_load) begin
            r_snap_cnt <= count;
            r_snap_dir <= direction;
         end
         r_an        <= w_an_next;
         r_seg       <= w_seg;
      end
   end

   assign seg = r_seg;
   assign an  = r_an;
   assign dp  = 1'b1;

endmodule
`default_nettype wire

// File: doc/sevenseg_scan_driver.md
SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clocks per digit slot; SHALL be >= 4.
REQ-002 Parameter BLANK_CYCLES, default 1000, inter-digit blanking clocks; SHALL be >= 1 and < REFRESH_DIV.
REQ-003 Port clk, input, 1, single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1, reset; SHALL be synchronous and active-high.
REQ-005 Port count, input, 4, unsigned up/down counter value to display (0..15).
REQ-006 Port direction, input, 1, counter mode: 1 = up, 0 = down.
REQ-007 Port seg, output, 7, cathodes {g,f,e,d,c,b,a}, active-low.
REQ-008 Port an, output, 4, digit anodes, active-low; an[0] is the rightmost digit.
REQ-009 Port dp, output, 1, decimal point, active-low; SHALL be held 1 (off).

Function
REQ-010 Free-running slot counter rcnt SHALL count 0..REFRESH_DIV-1, then wrap to 0.
REQ-011 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 when rcnt == REFRESH_DIV-1.
REQ-012 Snapshot {snap_dir, snap_cnt} SHALL load {direction, count} only when rcnt == REFRESH_DIV-1 and idx == 3, so each 4-slot frame shows one coherent value.
REQ-013 Mid-frame changes of count/direction SHALL NOT alter the displayed digits until the next frame.
REQ-014 Digit map: idx 0 = units of snap_cnt (0..9); idx 1 = tens (1 if snap_cnt >= 10, otherwise blank); idx 2 = blank; idx 3 = 'U' if snap_dir = 1, 'd' if snap_dir = 0.
REQ-015 Blank digit SHALL drive seg = 7'b1111111 with its anode still asserted.
REQ-016 Glyphs: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, U = 1000001, d = 0100001.
REQ-017 seg and an SHALL be registered and SHALL reflect (idx, rcnt, snapshot) with exactly 1 clock of latency.
REQ-018 Exactly one anode SHALL be low at any time outside blanking and reset.
REQ-019 Binary-to-BCD conversion SHALL be by compare-and-subtract of 10, with no divider.

Reset
REQ-020 While rst = 1 at a clock edge: rcnt = 0, idx = 0, snap_cnt = 0, snap_dir = 0, an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-021 In the first cycle after rst deasserts, the block SHALL capture {direction, count} into the snapshot.
REQ-022 Reset asserted mid-slot or mid-frame SHALL abort the scan with no partial-digit output on the following edge.

Configuration
REQ-023 Macro SEVENSEG_GHOST_BLANK_EN: when defined, an SHALL be 4'b1111 while rcnt < BLANK_CYCLES in every slot.
REQ-024 When SEVENSEG_GHOST_BLANK_EN is undefined, BLANK_CYCLES SHALL be ignored and the anode SHALL stay asserted for the full slot.

Structure
REQ-025 Package sevenseg_pkg SHALL hold the glyph constants (digits 0-9, U, d, BLANK) and the digit-index enum.
REQ-026 Sub-module bin_to_7seg (4-bit value plus blank flag in, 7-bit active-low pattern out, combinational) SHALL perform the glyph decode.

Verification (REFRESH_DIV = 4, BLANK_CYCLES = 1)
REQ-027 rst held 3 clocks -> an = 1111, seg = 1111111, dp = 1 throughout; after release, an[0] goes low within 2 clocks (macro undefined).
REQ-028 count = 12, direction = 1 -> one frame shows an 1110/seg 0100100, an 1101/seg 1111001, an 1011/seg 1111111, an 0111/seg 1000001.
REQ-029 count = 7, direction = 0 -> tens slot seg = 1111111; idx 3 slot seg = 0100001.
REQ-030 count changes 3 -> 4 while idx = 1 -> units digit shows 3 for the rest of that frame and 4 from the next frame.
REQ-031 SEVENSEG_GHOST_BLANK_EN defined -> an = 1111 for exactly 1 clock at the start of each slot; count 15 -> 0 wrap shows units 5 then units 0 with tens blank.
